// File: rtl/decimal_key_debouncer.sv
// Decimal keypad debouncer: two-flop synchronizer, zero/one-hot/multi
// classification and a four-state debounce FSM producing a registered
// one-hot key code with press and multi-key event pulses.
module decimal_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_raw,
  output logic [9:0] key_onehot,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Synchronizer stages
  logic [9:0]  sync1_reg;
  logic [9:0]  sync2_reg;
  logic [9:0]  key_sync;

  // FSM state and datapath
  state_t      state_reg, state_next;
  logic [9:0]  cand_reg, cand_next;
  logic [15:0] cnt_reg, cnt_next;

  // Registered outputs
  logic [9:0]  onehot_reg, onehot_next;
  logic        valid_reg, valid_next;
  logic        held_reg, held_next;
  logic        multi_reg, multi_next;
  // Remembers that the current multi-key pattern was already reported
  logic        multi_seen_reg, multi_seen_next;

  // Classification of the synchronized key lines
  logic        is_zero;
  logic        is_onehot;
  logic        is_multi;
  logic        match_cand;
  logic        cnt_done;
  logic        accept;
  logic        release_done;

  assign key_sync = sync2_reg;

  // Clearing the lowest set bit leaves zero only when at most one bit is set
  assign is_zero    = (key_sync == 10'd0);
  assign is_onehot  = !is_zero && ((key_sync & (key_sync - 10'd1)) == 10'd0);
  assign is_multi   = !is_zero && !is_onehot;
  assign match_cand = (key_sync == cand_reg);
  assign cnt_done   = (cnt_reg == CNT_LAST);

  assign accept       = (state_reg == DEBOUNCE) && match_cand && cnt_done;
  assign release_done = (state_reg == RELEASE) && is_zero && cnt_done;

  // Two-flop synchronizer for the asynchronous key lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 10'd0;
      sync2_reg <= 10'd0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cand_reg       <= 10'd0;
      cnt_reg        <= 16'd0;
      onehot_reg     <= 10'd0;
      valid_reg      <= 1'b0;
      held_reg       <= 1'b0;
      multi_reg      <= 1'b0;
      multi_seen_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cand_reg       <= cand_next;
      cnt_reg        <= cnt_next;
      onehot_reg     <= onehot_next;
      valid_reg      <= valid_next;
      held_reg       <= held_next;
      multi_reg      <= multi_next;
      multi_seen_reg <= multi_seen_next;
    end
  end

  // Next-state, candidate and counter logic
  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (is_onehot) begin
          cand_next  = key_sync;
          cnt_next   = 16'd0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (match_cand) begin
          if (cnt_done) begin
            cnt_next   = 16'd0;
            state_next = PRESSED;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end else begin
          cnt_next   = 16'd0;
          state_next = IDLE;
        end
      end
      PRESSED: begin
        // Added or changed keys while held are ignored until full release
        if (is_zero) begin
          cnt_next   = 16'd0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (is_zero) begin
          if (cnt_done) begin
            cnt_next   = 16'd0;
            cand_next  = 10'd0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end else begin
          cnt_next   = 16'd0;
          state_next = PRESSED;
        end
      end
      default: begin
        cnt_next   = 16'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    onehot_next     = onehot_reg;
    valid_next      = 1'b0;
    held_next       = held_reg;
    multi_next      = 1'b0;
    multi_seen_next = is_multi;
    if (accept) begin
      onehot_next = cand_reg;
      valid_next  = 1'b1;
      held_next   = 1'b1;
    end else if (release_done) begin
      onehot_next = 10'd0;
      held_next   = 1'b0;
    end
    // Report a multi-key pattern once, not on every cycle it stays present
    if ((state_reg == IDLE) && is_multi && !multi_seen_reg) begin
      multi_next = 1'b1;
    end
  end

  assign key_onehot = onehot_reg;
  assign key_valid  = valid_reg;
  assign key_held   = held_reg;
  assign multi_err  = multi_reg;

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Self-checking bench for decimal_key_debouncer with an event scoreboard.
module tb_decimal_key_debouncer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key_raw = 10'd0;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  typedef struct {
    int         cyc;
    logic [9:0] code;
  } exp_t;

  exp_t valid_q[$];
  int   multi_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  decimal_key_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_err  (multi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops expected events as the DUT produces them
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        checks++;
        if (valid_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d got key_onehot=%b required no pulse", cyc, key_onehot);
        end else begin
          exp_t e;
          e = valid_q.pop_front();
          if (cyc !== e.cyc || key_onehot !== e.code) begin
            failures++;
            $display("FAIL valid_event got cyc=%0d code=%b required cyc=%0d code=%b", cyc, key_onehot, e.cyc, e.code);
          end else begin
            $display("valid cyc=%0d code=%b", cyc, key_onehot);
          end
        end
      end
      if (valid_q.size() > 0 && valid_q[0].cyc < cyc) begin
        exp_t m;
        m = valid_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_valid got none by cyc=%0d required cyc=%0d code=%b", cyc, m.cyc, m.code);
      end
      if (multi_err) begin
        checks++;
        if (multi_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_multi_err cyc=%0d got 1 required 0", cyc);
        end else begin
          int mc;
          mc = multi_q.pop_front();
          if (cyc !== mc) begin
            failures++;
            $display("FAIL multi_err_event got cyc=%0d required cyc=%0d", cyc, mc);
          end else begin
            $display("multi_err cyc=%0d", cyc);
          end
        end
      end
      if (multi_q.size() > 0 && multi_q[0] < cyc) begin
        int mm;
        mm = multi_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_multi_err got none by cyc=%0d required cyc=%0d", cyc, mm);
      end
      checks++;
      if ($countones(key_onehot) > 1 || key_held !== (key_onehot != 10'd0)) begin
        failures++;
        $display("FAIL onehot_held_invariant cyc=%0d got onehot=%b held=%b required zero-or-onehot with matching held",
                 cyc, key_onehot, key_held);
      end
    end
  end

  task automatic drive_key(input logic [9:0] code);
    @(negedge clk);
    key_raw = code;
  endtask

  // Key drives start at a negedge; the acceptance edge is N+3 edges later
  task automatic press_expect(input logic [9:0] code);
    drive_key(code);
    valid_q.push_back('{cyc + N + 3, code});
  endtask

  task automatic release_and_check(input logic [9:0] code, input string name);
    drive_key(10'd0);
    repeat (N + 2) @(negedge clk);
    checks++;
    if (key_onehot !== code) begin
      failures++;
      $display("FAIL %s_release_early got onehot=%b required %b", name, key_onehot, code);
    end
    @(negedge clk);
    checks++;
    if (key_onehot !== 10'd0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL %s_release_clear got onehot=%b held=%b required 0 0", name, key_onehot, key_held);
    end
    $display("release %s code=%b cyc=%0d", name, code, cyc);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_raw = 10'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_onehot !== 10'd0 || key_valid !== 1'b0 || key_held !== 1'b0 || multi_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got onehot=%b valid=%b held=%b multi=%b required all 0",
               key_onehot, key_valid, key_held, multi_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_press();
    logic [9:0] code;
    code = 10'b0000001000;
    press_expect(code);
    repeat (N + 4) @(negedge clk);
    checks++;
    if (key_onehot !== code || key_held !== 1'b1 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL press_hold got onehot=%b held=%b valid=%b required %b 1 0", key_onehot, key_held, key_valid, code);
    end
    release_and_check(code, "press");
  endtask

  task automatic test_bounce();
    logic [9:0] code;
    code = 10'b0000000100;
    drive_key(code);
    repeat (2) @(negedge clk);
    drive_key(10'd0);
    repeat (12) @(negedge clk);
    checks++;
    if (key_onehot !== 10'd0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL bounce_reject got onehot=%b held=%b required 0 0", key_onehot, key_held);
    end
    // A clean press right after must be accepted with normal latency
    press_expect(code);
    repeat (N + 4) @(negedge clk);
    checks++;
    if (key_onehot !== code) begin
      failures++;
      $display("FAIL bounce_then_press got onehot=%b required %b", key_onehot, code);
    end
    release_and_check(code, "bounce");
  endtask

  task automatic test_multi();
    logic [9:0] code;
    drive_key(10'b0000000011);
    multi_q.push_back(cyc + 3);
    repeat (8) @(negedge clk);
    checks++;
    if (key_onehot !== 10'd0 || key_held !== 1'b0 || multi_q.size() != 0) begin
      failures++;
      $display("FAIL multi_pattern got onehot=%b held=%b pending_multi=%0d required 0 0 0",
               key_onehot, key_held, multi_q.size());
    end
    code = 10'b0000000001;
    press_expect(code);
    repeat (N + 4) @(negedge clk);
    checks++;
    if (key_onehot !== code || valid_q.size() != 0) begin
      failures++;
      $display("FAIL multi_then_single got onehot=%b pending_valid=%0d required %b 0",
               key_onehot, valid_q.size(), code);
    end
    release_and_check(code, "multi");
  endtask

  task automatic test_rerelease();
    logic [9:0] code;
    code = 10'b1000000000;
    press_expect(code);
    repeat (N + 4) @(negedge clk);
    drive_key(10'd0);
    drive_key(code);
    repeat (10) @(negedge clk);
    checks++;
    if (key_onehot !== code || key_held !== 1'b1) begin
      failures++;
      $display("FAIL rerelease_hold got onehot=%b held=%b required %b 1", key_onehot, key_held, code);
    end
    release_and_check(code, "rerelease");
  endtask

  task automatic test_add_key();
    logic [9:0] code;
    code = 10'b0000100000;
    press_expect(code);
    repeat (N + 4) @(negedge clk);
    drive_key(10'b0000100100);
    repeat (10) @(negedge clk);
    checks++;
    if (key_onehot !== code || key_held !== 1'b1) begin
      failures++;
      $display("FAIL add_key_hold got onehot=%b held=%b required %b 1", key_onehot, key_held, code);
    end
    release_and_check(code, "add_key");
  endtask

  task automatic test_reset_mid();
    logic [9:0] code;
    code = 10'b0010000000;
    press_expect(code);
    repeat (N + 4) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (key_onehot !== 10'd0 || key_held !== 1'b0 || key_valid !== 1'b0 || multi_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async got onehot=%b held=%b valid=%b multi=%b required all 0",
               key_onehot, key_held, key_valid, multi_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    valid_q.push_back('{cyc + N + 3, code});
    repeat (N + 4) @(negedge clk);
    checks++;
    if (key_onehot !== code || valid_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_repress got onehot=%b pending_valid=%0d required %b 0",
               key_onehot, valid_q.size(), code);
    end
    release_and_check(code, "reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [9:0] code;
      code = 10'd1 << $urandom_range(0, 9);
      press_expect(code);
      repeat (N + 4) @(negedge clk);
      checks++;
      if (key_onehot !== code) begin
        failures++;
        $display("FAIL back_to_back_%0d got onehot=%b required %b", i, key_onehot, code);
      end
      release_and_check(code, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_multi();
    test_rerelease();
    test_add_key();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (valid_q.size() != 0 || multi_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got valid=%0d multi=%0d pending required 0 0", valid_q.size(), multi_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
